weight_loader: RTL and testbench
================================

WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 SHALL take parameter SYS_COLS, default sys_cols (Config): number of weight-buffer columns driven.
REQ-002 SHALL take parameter WB, default W_BITWIDTH (Config): weight word width.
REQ-003 SHALL take parameter DEPTH, default w_buffer_depth (Config): maximum rows per column FIFO.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-007 SHALL have port rows_cfg  input  $clog2(DEPTH)+1  rows to load, sampled on accepted start.
REQ-008 SHALL have port s_valid  input  1  source word valid.
REQ-009 SHALL have port s_data  input  WB  source weight word, column-major within a row.
REQ-010 SHALL have port s_ready  output  1  loader accepts s_data this cycle.
REQ-011 SHALL have port wr_en  output  SYS_COLS  per-column weight-buffer write enable.
REQ-012 SHALL have port o_data  output  SYS_COLS x WB  per-column write data.
REQ-013 SHALL have port busy  output  1  load in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse, load complete.
REQ-015 SHALL have port err  output  1  one-cycle pulse, rejected start.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-017 IDLE: start=1 with 1 <= rows_cfg <= DEPTH -> LOAD; latch rows_cfg; col counter=0, row counter=0.
REQ-018 IDLE: start=1 with rows_cfg=0 or rows_cfg>DEPTH -> stay IDLE; err=1 for the next cycle.
REQ-019 s_ready SHALL equal 1 only in LOAD; handshake = s_valid & s_ready.
REQ-020 On handshake: wr_en[col]=1 and o_data[col]=s_data on the next cycle (latency 1, registered).
REQ-021 wr_en SHALL be one-hot or zero every cycle; no handshake -> wr_en=0 next cycle.
REQ-022 o_data lanes not written SHALL hold their previous value.
REQ-023 On handshake: col increments; col=SYS_COLS-1 wraps to 0 and row increments.
REQ-024 Handshake with row=rows_cfg-1, col=SYS_COLS-1 SHALL be the last word; state -> DONE.
REQ-025 DONE lasts exactly one cycle; done=1 in that cycle, coincident with the last wr_en; then IDLE.
REQ-026 busy SHALL be 1 in LOAD and DONE, 0 in IDLE.
REQ-027 start in LOAD or DONE SHALL be ignored: no err, no counter change.
REQ-028 s_valid=0 in LOAD SHALL stall with counters held; stalls of any length are legal.
REQ-029 Total writes per load SHALL equal rows_cfg x SYS_COLS, exactly rows_cfg per column.
REQ-030 A new start SHALL be accepted in the first IDLE cycle after DONE (back-to-back loads).

Reset
REQ-031 rst=0 SHALL immediately force IDLE, counters=0, and wr_en, o_data, busy, done, err, s_ready all 0.
REQ-032 Reset mid-LOAD SHALL discard the partial load, with no done pulse and no further wr_en.
REQ-033 After rst deasserts, the first start SHALL be accepted on the next clock edge.

Verification
REQ-034 SYS_COLS=4, rows_cfg=2, s_valid held 1, s_data=1..8 -> wr_en 0001,0010,0100,1000 repeated twice; o_data[c] ends at c+5; done on cycle 8 after first handshake.
REQ-035 rows_cfg=0, then rows_cfg=DEPTH+1 -> err pulses once each; busy stays 0; no wr_en.
REQ-036 rows_cfg=1 with s_valid toggling 1,0,0,1,1,0,1 -> exactly 4 writes in column order; done with the 4th.
REQ-037 Reset asserted after 3 of 8 words -> outputs 0 asynchronously; new load rows_cfg=1 writes column 0 first.
REQ-038 start pulsed during LOAD -> ignored, no err; second start in the first IDLE cycle after done -> accepted.

Source files
------------

// File: rtl/weight_loader.sv
// -----------------------------------------------------------------------------
// weight_loader
//   Streams weight words from a valid/ready source into SYS_COLS column
//   weight buffers. Words arrive column-major within a row: column 0..N-1 of
//   row 0, then row 1, and so on. A load covers rows_cfg rows. Each accepted
//   word appears one cycle later as a single wr_en lane carrying o_data.
//
// Ports
//   clk       : clock, all state changes on its rising edge
//   rst       : asynchronous active-low reset
//   start     : one-cycle load request, honoured only while idle
//   rows_cfg  : rows to load (1..DEPTH), captured with an accepted start
//   s_valid   : source word valid
//   s_data    : source weight word
//   s_ready   : loader accepts s_data this cycle
//   wr_en     : per-column write enable, one-hot or zero
//   o_data    : per-column write data, unwritten lanes hold their value
//   busy      : load in progress (LOAD or DONE)
//   done      : one-cycle pulse alongside the last write
//   err       : one-cycle pulse after a start with rows_cfg out of range
// -----------------------------------------------------------------------------
module weight_loader #(
    parameter int SYS_COLS = 4,
    parameter int WB       = 8,
    parameter int DEPTH    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(DEPTH):0]        rows_cfg,
    input  logic                          s_valid,
    input  logic [WB-1:0]                 s_data,
    output logic                          s_ready,
    output logic [SYS_COLS-1:0]           wr_en,
    output logic [SYS_COLS-1:0][WB-1:0]   o_data,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int RW = $clog2(DEPTH) + 1;
    localparam int CW = (SYS_COLS > 1) ? $clog2(SYS_COLS) : 1;

    localparam logic [RW-1:0] DEPTH_L  = RW'(DEPTH);
    localparam logic [CW-1:0] COL_LAST = CW'(SYS_COLS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [RW-1:0]                 rows_q, rows_d;
    logic [RW-1:0]                 row_q, row_d;
    logic [CW-1:0]                 col_q, col_d;
    logic [SYS_COLS-1:0]           wr_en_q, wr_en_d;
    logic [SYS_COLS-1:0][WB-1:0]   o_data_q, o_data_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          err_q, err_d;
    logic                          s_ready_q, s_ready_d;
    logic                          hs_s;

    // Next-state, counter and output computation.
    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        row_d     = row_q;
        col_d     = col_q;
        wr_en_d   = '0;
        o_data_d  = o_data_q;
        err_d     = 1'b0;
        hs_s      = s_valid & s_ready_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((rows_cfg != {RW{1'b0}}) && (rows_cfg <= DEPTH_L)) begin
                        state_d = ST_LOAD;
                        rows_d  = rows_cfg;
                        row_d   = {RW{1'b0}};
                        col_d   = {CW{1'b0}};
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // Counters move only on a handshake; a stall holds everything.
                if (hs_s) begin
                    wr_en_d[col_q]  = 1'b1;
                    o_data_d[col_q] = s_data;
                    if (col_q == COL_LAST) begin
                        col_d = {CW{1'b0}};
                        if (row_q == (rows_q - RW'(1))) begin
                            state_d = ST_DONE;
                            row_d   = {RW{1'b0}};
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags follow the state being entered so they are flops, not decodes.
        busy_d    = (state_d != ST_IDLE);
        s_ready_d = (state_d == ST_LOAD);
        done_d    = (state_d == ST_DONE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rows_q    <= {RW{1'b0}};
            row_q     <= {RW{1'b0}};
            col_q     <= {CW{1'b0}};
            wr_en_q   <= '0;
            o_data_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            row_q     <= row_d;
            col_q     <= col_d;
            wr_en_q   <= wr_en_d;
            o_data_q  <= o_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            s_ready_q <= s_ready_d;
        end
    end

    assign s_ready = s_ready_q;
    assign wr_en   = wr_en_q;
    assign o_data  = o_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_weight_loader.sv
// -----------------------------------------------------------------------------
// tb_weight_loader
//   Self-checking bench for weight_loader. A word-count model predicts, for
//   every clock edge, which lane is written, the lane contents and the status
//   flags. Directed scenarios cover the documented cases; randomized loads with
//   random stalls and stray start pulses follow.
// -----------------------------------------------------------------------------
module tb_weight_loader;

    localparam int C  = 4;
    localparam int W  = 8;
    localparam int D  = 8;
    localparam int RW = $clog2(D) + 1;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic [RW-1:0]         rows_cfg;
    logic                  s_valid;
    logic [W-1:0]          s_data;
    logic                  s_ready;
    logic [C-1:0]          wr_en;
    logic [C-1:0][W-1:0]   o_data;
    logic                  busy;
    logic                  done;
    logic                  err;

    weight_loader #(.SYS_COLS(C), .WB(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rows_cfg (rows_cfg),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .wr_en    (wr_en),
        .o_data   (o_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Reference model: a load is "n of total words accepted"; word n lands in column n % C.
    bit                  m_active;
    bit                  m_in_done;
    int                  m_count;
    int                  m_total;
    logic [C-1:0]        e_wr;
    logic [C-1:0][W-1:0] e_data;
    logic                e_busy, e_done, e_err, e_ready;
    int                  obs_writes [C];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_active  = 1'b0;
        m_in_done = 1'b0;
        m_count   = 0;
        m_total   = 0;
        e_wr      = '0;
        e_data    = '0;
        e_busy    = 1'b0;
        e_done    = 1'b0;
        e_err     = 1'b0;
        e_ready   = 1'b0;
    endtask

    // Apply the inputs present at a rising edge to the model.
    task automatic model_step();
        int c;
        e_wr   = '0;
        e_err  = 1'b0;
        e_done = 1'b0;
        if (m_active) begin
            if (s_valid) begin
                c         = m_count % C;
                e_wr[c]   = 1'b1;
                e_data[c] = s_data;
                m_count++;
                if (m_count == m_total) begin
                    m_active  = 1'b0;
                    m_in_done = 1'b1;
                    e_done    = 1'b1;
                end
            end
        end else if (m_in_done) begin
            m_in_done = 1'b0;
        end else if (start) begin
            if (rows_cfg >= 1 && int'(rows_cfg) <= D) begin
                m_active = 1'b1;
                m_count  = 0;
                m_total  = int'(rows_cfg) * C;
            end else begin
                e_err = 1'b1;
            end
        end
        e_busy  = m_active | m_in_done;
        e_ready = m_active;
    endtask

    task automatic compare_all();
        chk("wr_en",   32'(wr_en),   32'(e_wr));
        chk("o_data",  32'(o_data),  32'(e_data));
        chk("busy",    32'(busy),    32'(e_busy));
        chk("done",    32'(done),    32'(e_done));
        chk("err",     32'(err),     32'(e_err));
        chk("s_ready", 32'(s_ready), 32'(e_ready));
        for (int c = 0; c < C; c++) begin
            if (wr_en[c]) obs_writes[c]++;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic clear_writes();
        for (int c = 0; c < C; c++) obs_writes[c] = 0;
    endtask

    // Asynchronous reset applied mid-cycle; released away from the clock edge.
    task automatic mid_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One randomized load with random stalls and stray start pulses.
    task automatic random_load();
        int  rows;
        int  budget;
        bit  ok;
        rows     = $urandom_range(0, D + 1);
        ok       = (rows >= 1 && rows <= D);
        clear_writes();
        start    = 1'b1;
        rows_cfg = RW'(rows);
        cyc();
        start    = 1'b0;
        budget   = 0;
        while ((m_active || m_in_done) && budget < 600) begin
            s_valid  = ($urandom_range(0, 9) < 7);
            s_data   = W'($urandom);
            start    = ($urandom_range(0, 15) == 0);
            rows_cfg = RW'($urandom_range(0, D + 1));
            cyc();
            budget++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        cyc();
        chk("load_end_busy", 32'(busy), 32'd0);
        for (int c = 0; c < C; c++) begin
            chk("col_writes", 32'(obs_writes[c]), ok ? 32'(rows) : 32'd0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        start    = 1'b0;
        rows_cfg = '0;
        s_valid  = 1'b0;
        s_data   = '0;
        model_reset();
        clear_writes();
        #3;
        compare_all();
        @(negedge clk);
        rst = 1'b1;
        cyc();

        // Two rows, source always valid, words 1..8.
        start    = 1'b1;
        rows_cfg = RW'(2);
        cyc();
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            s_valid = 1'b1;
            s_data  = W'(i);
            cyc();
        end
        chk("done_on_8th", 32'(done), 32'd1);
        s_valid = 1'b0;
        cyc();
        for (int c = 0; c < C; c++) chk("lane_final", 32'(o_data[c]), 32'(c + 5));

        // Rejected starts: zero rows, then one past the depth.
        start    = 1'b1;
        rows_cfg = '0;
        cyc();
        start = 1'b0;
        cyc();
        start    = 1'b1;
        rows_cfg = RW'(D + 1);
        cyc();
        start = 1'b0;
        cyc();
        cyc();

        // One row with s_valid toggling 1,0,0,1,1,0,1.
        start    = 1'b1;
        rows_cfg = RW'(1);
        cyc();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            s_valid = (i == 0 || i == 3 || i == 4 || i == 6);
            s_data  = W'(8'h30 + i);
            cyc();
        end
        chk("toggle_done", 32'(done), 32'd1);
        s_valid = 1'b0;
        cyc();

        // Reset after 3 of 8 words, then a one-row load starts at column 0.
        start    = 1'b1;
        rows_cfg = RW'(2);
        cyc();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = W'(8'hA0 + i);
            cyc();
        end
        s_valid = 1'b0;
        mid_reset();
        start    = 1'b1;
        rows_cfg = RW'(1);
        cyc();
        chk("start_after_rst", 32'(busy), 32'd1);
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h5A;
        cyc();
        chk("rst_first_col", 32'(wr_en), 32'b0001);
        for (int i = 1; i < 4; i++) begin
            s_data = W'(8'h5A + i);
            cyc();
        end
        s_valid = 1'b0;
        cyc();

        // Start during LOAD ignored; start during DONE ignored; start in first IDLE accepted.
        start    = 1'b1;
        rows_cfg = RW'(1);
        cyc();
        for (int i = 0; i < C; i++) begin
            start    = 1'b1;
            rows_cfg = '0;
            s_valid  = 1'b1;
            s_data   = W'(8'hC0 + i);
            cyc();
        end
        s_valid  = 1'b0;
        start    = 1'b1;
        rows_cfg = RW'(1);
        cyc();
        chk("idle_after_done", 32'(busy), 32'd0);
        cyc();
        chk("b2b_accepted", 32'(s_ready), 32'd1);
        start = 1'b0;
        for (int i = 0; i < C; i++) begin
            s_valid = 1'b1;
            s_data  = W'($urandom);
            cyc();
        end
        s_valid = 1'b0;
        cyc();

        // Randomized loads.
        for (int n = 0; n < 25; n++) random_load();

        // Randomized mid-load resets.
        for (int n = 0; n < 4; n++) begin
            start    = 1'b1;
            rows_cfg = RW'($urandom_range(1, D));
            cyc();
            start = 1'b0;
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
                s_valid = 1'b1;
                s_data  = W'($urandom);
                cyc();
            end
            s_valid = 1'b0;
            mid_reset();
            cyc();
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
